// File: rtl/tl_pkg.sv
// Shared TileLink-UL definitions: opcodes, arbiter FSM states and beat-count helpers.
package tl_pkg;

  localparam logic [2:0] PutFullData    = 3'd0;
  localparam logic [2:0] PutPartialData = 3'd1;
  localparam logic [2:0] ArithmeticData = 3'd2;
  localparam logic [2:0] LogicalData    = 3'd3;
  localparam logic [2:0] Get            = 3'd4;
  localparam logic [2:0] AccessAck      = 3'd0;
  localparam logic [2:0] AccessAckData  = 3'd1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    BURST = 2'd2
  } arb_state_e;

  // A 4-byte bus carries 2^(size-2) beats; sizes above 12 saturate at 1024 beats.
  function automatic logic [10:0] tl_beats(input logic [3:0] size);
    logic [10:0] beats;
    if (size <= 4'd2) begin
      beats = 11'd1;
    end else if (size >= 4'd12) begin
      beats = 11'd1024;
    end else begin
      beats = 11'd1 << (size - 4'd2);
    end
    return beats;
  endfunction

  function automatic logic tl_is_multi(input logic [2:0] opcode, input logic [3:0] size);
    logic has_data;
    has_data = (opcode == PutFullData) || (opcode == PutPartialData) ||
               (opcode == ArithmeticData) || (opcode == LogicalData);
    return has_data && (size > 4'd2);
  endfunction

endpackage

// File: rtl/tlul_arb2.sv
// Two-requester TileLink-UL arbiter: round-robin A channel that locks across pending
// beats and bursts, with source-tagged D channel routing back to the requesters.
module tlul_arb2
  import tl_pkg::*;
#(
  parameter int TL_RS = 4,
  parameter int TL_AW = 16
) (
  input  logic               arb_clock_i,
  input  logic               arb_reset_ni,

  input  logic [2:0]         m0_a_opcode,
  input  logic [2:0]         m0_a_param,
  input  logic [3:0]         m0_a_size,
  input  logic [TL_RS-1:0]   m0_a_source,
  input  logic [TL_AW-1:0]   m0_a_address,
  input  logic [3:0]         m0_a_mask,
  input  logic [31:0]        m0_a_data,
  input  logic               m0_a_corrupt,
  input  logic               m0_a_valid,
  output logic               m0_a_ready,
  output logic [2:0]         m0_d_opcode,
  output logic [1:0]         m0_d_param,
  output logic [3:0]         m0_d_size,
  output logic [TL_RS-1:0]   m0_d_source,
  output logic               m0_d_denied,
  output logic [31:0]        m0_d_data,
  output logic               m0_d_corrupt,
  output logic               m0_d_valid,
  input  logic               m0_d_ready,

  input  logic [2:0]         m1_a_opcode,
  input  logic [2:0]         m1_a_param,
  input  logic [3:0]         m1_a_size,
  input  logic [TL_RS-1:0]   m1_a_source,
  input  logic [TL_AW-1:0]   m1_a_address,
  input  logic [3:0]         m1_a_mask,
  input  logic [31:0]        m1_a_data,
  input  logic               m1_a_corrupt,
  input  logic               m1_a_valid,
  output logic               m1_a_ready,
  output logic [2:0]         m1_d_opcode,
  output logic [1:0]         m1_d_param,
  output logic [3:0]         m1_d_size,
  output logic [TL_RS-1:0]   m1_d_source,
  output logic               m1_d_denied,
  output logic [31:0]        m1_d_data,
  output logic               m1_d_corrupt,
  output logic               m1_d_valid,
  input  logic               m1_d_ready,

  output logic [2:0]         s_a_opcode,
  output logic [2:0]         s_a_param,
  output logic [3:0]         s_a_size,
  output logic [TL_RS:0]     s_a_source,
  output logic [TL_AW-1:0]   s_a_address,
  output logic [3:0]         s_a_mask,
  output logic [31:0]        s_a_data,
  output logic               s_a_corrupt,
  output logic               s_a_valid,
  input  logic               s_a_ready,

  input  logic [2:0]         s_d_opcode,
  input  logic [1:0]         s_d_param,
  input  logic [3:0]         s_d_size,
  input  logic [TL_RS:0]     s_d_source,
  input  logic               s_d_denied,
  input  logic [31:0]        s_d_data,
  input  logic               s_d_corrupt,
  input  logic               s_d_valid,
  output logic               s_d_ready
);

  arb_state_e  state_q, state_d;
  logic        grant_q, grant_d;
  logic        rr_last_q, rr_last_d;
  logic [10:0] cnt_q, cnt_d;
  logic        grant;
  logic        a_hs;
  logic        a_multi;
  logic        d_sel;

  // Only IDLE may pick a new winner; HOLD and BURST stay locked to the registered grant.
  always_comb begin
    grant = grant_q;
    if (state_q == IDLE) begin
      if (m0_a_valid && !m1_a_valid) begin
        grant = 1'b0;
      end else if (!m0_a_valid && m1_a_valid) begin
        grant = 1'b1;
      end else if (m0_a_valid && m1_a_valid) begin
        grant = ~rr_last_q;
      end
    end
  end

  assign s_a_opcode  = grant ? m1_a_opcode  : m0_a_opcode;
  assign s_a_param   = grant ? m1_a_param   : m0_a_param;
  assign s_a_size    = grant ? m1_a_size    : m0_a_size;
  assign s_a_source  = {grant, (grant ? m1_a_source : m0_a_source)};
  assign s_a_address = grant ? m1_a_address : m0_a_address;
  assign s_a_mask    = grant ? m1_a_mask    : m0_a_mask;
  assign s_a_data    = grant ? m1_a_data    : m0_a_data;
  assign s_a_corrupt = grant ? m1_a_corrupt : m0_a_corrupt;
  assign s_a_valid   = (grant ? m1_a_valid : m0_a_valid) & arb_reset_ni;
  assign m0_a_ready  = s_a_ready & ~grant & arb_reset_ni;
  assign m1_a_ready  = s_a_ready &  grant & arb_reset_ni;

  assign a_hs    = s_a_valid & s_a_ready;
  assign a_multi = tl_is_multi(s_a_opcode, s_a_size);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_last_d = rr_last_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        grant_d = grant;
        if (a_hs) begin
          if (a_multi) begin
            cnt_d   = tl_beats(s_a_size) - 11'd1;
            state_d = BURST;
          end else begin
            rr_last_d = grant;
          end
        end else if (s_a_valid) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (a_hs) begin
          if (a_multi) begin
            cnt_d   = tl_beats(s_a_size) - 11'd1;
            state_d = BURST;
          end else begin
            rr_last_d = grant_q;
            state_d   = IDLE;
          end
        end
      end
      BURST: begin
        if (a_hs) begin
          cnt_d = cnt_q - 11'd1;
          if (cnt_q == 11'd1) begin
            rr_last_d = grant_q;
            state_d   = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge arb_clock_i or negedge arb_reset_ni) begin
    if (!arb_reset_ni) begin
      state_q   <= IDLE;
      grant_q   <= 1'b0;
      rr_last_q <= 1'b1;
      cnt_q     <= 11'd0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_last_q <= rr_last_d;
      cnt_q     <= cnt_d;
    end
  end

  // D fields fan out to both requesters; only the valid selects who actually sees a beat.
  assign d_sel = s_d_source[TL_RS];

  assign m0_d_opcode  = s_d_opcode;
  assign m0_d_param   = s_d_param;
  assign m0_d_size    = s_d_size;
  assign m0_d_source  = s_d_source[TL_RS-1:0];
  assign m0_d_denied  = s_d_denied;
  assign m0_d_data    = s_d_data;
  assign m0_d_corrupt = s_d_corrupt;
  assign m0_d_valid   = s_d_valid & ~d_sel & arb_reset_ni;

  assign m1_d_opcode  = s_d_opcode;
  assign m1_d_param   = s_d_param;
  assign m1_d_size    = s_d_size;
  assign m1_d_source  = s_d_source[TL_RS-1:0];
  assign m1_d_denied  = s_d_denied;
  assign m1_d_data    = s_d_data;
  assign m1_d_corrupt = s_d_corrupt;
  assign m1_d_valid   = s_d_valid & d_sel & arb_reset_ni;

  assign s_d_ready = d_sel ? m1_d_ready : m0_d_ready;

endmodule
